// File: rtl/ref_mem_bank_array_if.sv
// Bus between the reference memory controller and the banked reference store.
// Carries the write enables, addresses and data, the read request, the rotated
// read row, the assembled search window and the out-of-range error pulse.
interface ref_mem_bank_array_if #(
   parameter int NUM_BANK = 32,
   parameter int ADDR_W   = 7,
   parameter int PIX_W    = 8
) ();
   logic [NUM_BANK-1:0]          Bank_sel;
   logic [NUM_BANK*ADDR_W-1:0]   write_address_all;
   logic [NUM_BANK*PIX_W-1:0]    wr_data;
   logic [ADDR_W-1:0]            rd_address;
   logic                         rd8R_en;
   logic [3:0]                   rdR_sel;
   logic [NUM_BANK*PIX_W-1:0]    rd_data;
   logic                         rd_valid;
   logic [4*NUM_BANK*PIX_W-1:0]  win_data;
   logic                         win_valid;
   logic [1:0]                   win_row_cnt;
   logic                         addr_err;

   modport master (
      output Bank_sel, write_address_all, wr_data,
      output rd_address, rd8R_en, rdR_sel,
      input  rd_data, rd_valid, win_data, win_valid,
      input  win_row_cnt, addr_err
   );

   modport slave (
      input  Bank_sel, write_address_all, wr_data,
      input  rd_address, rd8R_en, rdR_sel,
      output rd_data, rd_valid, win_data, win_valid,
      output win_row_cnt, addr_err
   );
endinterface

// File: rtl/ref_mem_bank_array.sv
// Banked reference-frame store: per-bank writes, shared-row rotated reads,
// and a 4-row search-window assembler.
// Ports: clk, rst (sync, active-high), bus (slave side of the controller bus).
module ref_mem_bank_array #(
   parameter int NUM_BANK = 32,
   parameter int DEPTH    = 96,
   parameter int ADDR_W   = 7,
   parameter int PIX_W    = 8,
   parameter int GROUP    = 4
) (
   input logic clk,
   input logic rst,
   ref_mem_bank_array_if.slave bus
);
   localparam int ROW_W = NUM_BANK * PIX_W;
   localparam int BW    = $clog2(NUM_BANK);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [PIX_W-1:0]  mem [NUM_BANK][DEPTH];
   logic [ROW_W-1:0]  stage [3];
   logic [ROW_W-1:0]  rot_row;
   logic [ROW_W-1:0]  rd_data_q;
   logic [4*ROW_W-1:0] win_data_q;
   logic [BW-1:0]     rot_base;
   logic [1:0]        cnt;
   logic              rd_ok, rd_bad, wr_bad;
   logic              rd_valid_q, win_valid_q, addr_err_q;
   logic              sel_unused;

   assign sel_unused = bus.rdR_sel[3];

   always_comb begin
      // Bank count is a power of two, so truncation is the modulo.
      rot_base = BW'(GROUP * int'(bus.rdR_sel[2:0]));
      rd_ok    = !bus.rd8R_en && (bus.rd_address < DEPTH_A);
      rd_bad   = !bus.rd8R_en && (bus.rd_address >= DEPTH_A);
      wr_bad   = 1'b0;
      for (int k = 0; k < NUM_BANK; k++) begin
         if (bus.Bank_sel[k] &&
             bus.write_address_all[k*ADDR_W +: ADDR_W] >= DEPTH_A)
            wr_bad = 1'b1;
      end
      rot_row = '0;
      for (int j = 0; j < NUM_BANK; j++) begin
         rot_row[j*PIX_W +: PIX_W] =
            mem[BW'(j) + rot_base][bus.rd_address];
      end
   end

   // Storage is never reset; non-blocking update gives read-first collisions.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_BANK; k++) begin
         if (bus.Bank_sel[k] &&
             bus.write_address_all[k*ADDR_W +: ADDR_W] < DEPTH_A)
            mem[k][bus.write_address_all[k*ADDR_W +: ADDR_W]] <=
               bus.wr_data[k*PIX_W +: PIX_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         win_data_q  <= '0;
         win_valid_q <= 1'b0;
         cnt         <= 2'd0;
         addr_err_q  <= 1'b0;
      end else begin
         rd_valid_q  <= rd_ok;
         addr_err_q  <= rd_bad | wr_bad;
         win_valid_q <= 1'b0;
         if (rd_ok) begin
            rd_data_q <= rot_row;
            if (cnt == 2'd3) begin
               // Rows 0..2 wait in stage so win_data only moves on a pulse.
               win_data_q  <= {rot_row, stage[2], stage[1], stage[0]};
               win_valid_q <= 1'b1;
               cnt         <= 2'd0;
            end else begin
               stage[cnt] <= rot_row;
               cnt        <= cnt + 2'd1;
            end
         end else begin
            cnt <= 2'd0;
         end
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.win_data    = win_data_q;
   assign bus.win_valid   = win_valid_q;
   assign bus.win_row_cnt = cnt;
   assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_ref_mem_bank_array.sv
// Self-checking bench for ref_mem_bank_array: directed plan plus random traffic
// compared against a behavioural model of memory, rotation and windowing.
module tb_ref_mem_bank_array;
   localparam int NB = 32;
   localparam int DP = 96;
   localparam int AW = 7;
   localparam int PW = 8;
   localparam int RW = NB * PW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ref_mem_bank_array_if bus ();

   ref_mem_bank_array dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]    mm [NB][DP];
   logic [RW-1:0] q [$];
   logic [RW-1:0] e_rd;
   logic [4*RW-1:0] e_wd;
   logic          e_rv, e_wv, e_err;
   int            pass_cnt = 0;
   int            total = 0;

   task automatic check(input string tag, input logic [RW-1:0] obs,
                        input logic [RW-1:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      bus.Bank_sel          = '0;
      bus.write_address_all = '0;
      bus.wr_data           = '0;
      bus.rd_address        = '0;
      bus.rd8R_en           = 1'b1;
      bus.rdR_sel           = '0;
   endtask

   // One clock: predict from the driven inputs, advance, compare everything.
   task automatic tick(input string tag);
      logic [RW-1:0] row;
      logic [AW-1:0] wa;
      int            b;
      bit            rv;
      if (rst) begin
         e_rd = '0; e_rv = 0; e_wd = '0; e_wv = 0; e_err = 0;
         q.delete();
      end else begin
         e_err = 0;
         for (int k = 0; k < NB; k++) begin
            wa = bus.write_address_all[k*AW +: AW];
            if (bus.Bank_sel[k] && int'(wa) >= DP) e_err = 1;
         end
         if (!bus.rd8R_en && int'(bus.rd_address) >= DP) e_err = 1;
         rv = !bus.rd8R_en && int'(bus.rd_address) < DP;
         e_wv = 0;
         if (rv) begin
            for (int j = 0; j < NB; j++) begin
               b = (j + 4 * int'(bus.rdR_sel[2:0])) % NB;
               row[j*PW +: PW] = mm[b][bus.rd_address];
            end
            e_rd = row;
            q.push_back(row);
            if (q.size() == 4) begin
               e_wd = {q[3], q[2], q[1], q[0]};
               e_wv = 1;
               q.delete();
            end
         end else begin
            q.delete();
         end
         e_rv = rv;
      end
      for (int k = 0; k < NB; k++) begin
         wa = bus.write_address_all[k*AW +: AW];
         if (bus.Bank_sel[k] && int'(wa) < DP)
            mm[k][wa] = bus.wr_data[k*PW +: PW];
      end
      @(posedge clk);
      #1;
      check({tag, ".rd_data"}, bus.rd_data, e_rd);
      check({tag, ".rd_valid"}, RW'(bus.rd_valid), RW'(e_rv));
      check({tag, ".addr_err"}, RW'(bus.addr_err), RW'(e_err));
      check({tag, ".win_valid"}, RW'(bus.win_valid), RW'(e_wv));
      check({tag, ".win_cnt"}, RW'(bus.win_row_cnt), RW'(q.size()));
      for (int r = 0; r < 4; r++)
         check($sformatf("%s.win%0d", tag, r),
               bus.win_data[r*RW +: RW], e_wd[r*RW +: RW]);
   endtask

   task automatic rd(input int a, input int sel);
      bus.rd8R_en    = 1'b0;
      bus.rd_address = AW'(a);
      bus.rdR_sel    = 4'(sel);
   endtask

   task automatic wr1(input int k, input int a, input logic [7:0] d);
      bus.Bank_sel[k]                    = 1'b1;
      bus.write_address_all[k*AW +: AW]  = AW'(a);
      bus.wr_data[k*PW +: PW]            = d;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick("reset");
      tick("reset2");
      rst = 1'b0;

      // Fill: bank k row a = (k+a) mod 256, four banks per cycle.
      for (int a = 0; a < DP; a++) begin
         for (int g = 0; g < NB / 4; g++) begin
            idle_inputs();
            for (int k = 4 * g; k < 4 * g + 4; k++) wr1(k, a, 8'(k + a));
            tick("fill");
         end
      end

      idle_inputs(); rd(10, 0); tick("row10");
      check("row10.lane0", RW'(bus.rd_data[7:0]), RW'(10));
      check("row10.lane31", RW'(bus.rd_data[255:248]), RW'(41));

      idle_inputs(); wr1(8, 5, 8'h55); wr1(0, 3, 8'h55); tick("w55");
      idle_inputs(); rd(5, 2); tick("rot2");
      check("rot2.lane0", RW'(bus.rd_data[7:0]), RW'(8'h55));
      check("rot2.lane31", RW'(bus.rd_data[255:248]), RW'(12));

      idle_inputs(); wr1(0, 3, 8'hAA); rd(3, 0); tick("coll");
      check("coll.old", RW'(bus.rd_data[7:0]), RW'(8'h55));
      idle_inputs(); rd(3, 0); tick("coll_next");
      check("coll.new", RW'(bus.rd_data[7:0]), RW'(8'hAA));
      idle_inputs(); tick("gap0");

      for (int r = 0; r < 4; r++) begin
         idle_inputs(); rd(r, 0); tick("win4");
      end
      check("win4.pulse", RW'(bus.win_valid), RW'(1));
      idle_inputs(); tick("gap1");

      idle_inputs(); rd(0, 0); tick("wg0");
      idle_inputs(); rd(1, 0); tick("wg1");
      idle_inputs(); tick("wg_gap");
      check("wg.cnt0", RW'(bus.win_row_cnt), RW'(0));
      for (int r = 2; r < 6; r++) begin
         idle_inputs(); rd(r, 1); tick("wg_r");
      end
      check("wg.row0_lane0", RW'(bus.win_data[7:0]), RW'(6));
      idle_inputs(); tick("gap2");

      idle_inputs(); rd(100, 0); tick("rd_oob");
      check("rd_oob.err", RW'(bus.addr_err), RW'(1));
      idle_inputs(); wr1(0, 127, 8'hEE); tick("wr_oob");
      idle_inputs(); rd(31, 0); tick("oob_row31");
      idle_inputs(); tick("gap3");

      idle_inputs(); rd(7, 3); tick("pre_rst0");
      idle_inputs(); rd(8, 3); tick("pre_rst1");
      idle_inputs(); rst = 1'b1; tick("rst_mid");
      check("rst_mid.rd_data", bus.rd_data, '0);
      rst = 1'b0;
      idle_inputs(); rd(9, 5); tick("post_rst");

      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         for (int k = 0; k < NB; k++) begin
            if ($urandom_range(0, 7) == 0)
               wr1(k, $urandom_range(0, 99), 8'($urandom));
         end
         if ($urandom_range(0, 9) < 8)
            rd($urandom_range(0, 101), $urandom_range(0, 15));
         tick("rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/ref_mem_bank_array.md
Name: ref_mem_bank_array

Overview:
- Banked on-chip reference-frame store: NUM_BANK single-port-per-direction banks, DEPTH rows each.
- Responder to the reference memory controller. Consumes its bank-select, per-bank write addresses, shared read address, active-low read enable and read-select.
- Returns rotated read rows to the PE array.
- Assembles 4 consecutive reads into a 4-row search window, i.e. the first search point's reference block.

Parameters:
- NUM_BANK, 32, number of banks; also the width of Bank_sel.
- DEPTH, 96, rows per bank; valid addresses are 0..DEPTH-1.
- ADDR_W, 7, row address width.
- PIX_W, 8, bits per bank word.
- GROUP, 4, banks per rotation step.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- Bank_sel  in  NUM_BANK  per-bank write enable; bit k enables bank k.
- write_address_all  in  NUM_BANK*ADDR_W  bank k's write row is bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_BANK*PIX_W  bank k's write word is bits [k*PIX_W +: PIX_W].
- rd_address  in  ADDR_W  row read from all banks at once.
- rd8R_en  in  1  read enable, active-low; 0 = read this cycle.
- rdR_sel  in  4  rotation select; bits [2:0] are used, bit 3 is reserved and ignored.
- rd_data  out  NUM_BANK*PIX_W  rotated read row.
- rd_valid  out  1  rd_data valid, one-cycle pulse per read.
- win_data  out  4*NUM_BANK*PIX_W  window; row r (first read = row 0) at bits [r*NUM_BANK*PIX_W +: NUM_BANK*PIX_W].
- win_valid  out  1  one-cycle pulse when the window is complete.
- win_row_cnt  out  2  rows collected in the current window.
- addr_err  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, win_data=0, win_valid=0, win_row_cnt=0, addr_err=0.
  - Memory contents are not reset and survive rst.
  - rst mid-window discards the partial window.
- Write path:
  - On each clk edge, for every k with Bank_sel[k]=1 and its write address < DEPTH, bank k at that address takes wr_data slice k.
  - Banks with Bank_sel[k]=0 are untouched.
  - Any enabled bank whose address >= DEPTH does not write.
- Read path (1-cycle latency):
  - If rd8R_en=0 and rd_address<DEPTH in cycle T, then in T+1: rd_valid=1, and lane j of rd_data = bank ((j + GROUP*rdR_sel[2:0]) mod NUM_BANK) at row rd_address.
  - rdR_sel is sampled in cycle T.
  - Otherwise rd_valid=0 in T+1 and rd_data holds its previous value.
- Read/write collision (same bank, same row, same cycle): read-first. The read returns the old word; the new word is visible from the next read.
- addr_err = 1 in T+1 if, in cycle T, either:
  - any Bank_sel[k]=1 has its address >= DEPTH, or
  - rd8R_en=0 with rd_address >= DEPTH.
  - An out-of-range read counts as a gap (see window rules).
- Window assembler, states EMPTY (cnt=0) and FILLING (cnt=1..3):
  - Each valid read (an in-range read in cycle T) writes its rotated row into window row win_row_cnt in T+1.
  - win_row_cnt is the count of rows already captured.
  - On the 4th consecutive valid read, win_valid=1 in T+1, in the same cycle as that read's rd_valid, with rows 0..3 in read order. win_row_cnt returns to 0.
  - Any cycle without a valid read while cnt≠0 (a gap) resets win_row_cnt to 0. The partial window is discarded, win_valid stays 0, and win_data is left unchanged.
  - win_data changes only when win_valid pulses; it holds between windows.
  - Back-to-back reads yield a win_valid pulse every 4th cycle.

Test Plan:
- Write pattern bank k, row a = (k+a) mod 256 with Bank_sel=0x0000000F, then 0x000000F0, and so on up to row 95. Read row 10 with rdR_sel=0 → rd_valid one cycle later, lane j = j+10.
- Write 0x55 then read row 5 with rdR_sel=2 → lane 0 holds bank 8's word and lane 31 holds bank 7's.
- Same-cycle write 0xAA and read of bank 0 row 3 (old 0x55) → rd_data lane 0 = 0x55; the next read returns 0xAA.
- 4 back-to-back reads of rows 0..3 with rd8R_en=0 → win_row_cnt steps 1,2,3,0; win_valid pulses once; win_data rows 0..3 = rows 0..3.
- Reads of rows 0,1, one idle cycle, then rows 2..5 → win_row_cnt goes 1,2,0 at the gap; win_valid pulses only after row 5, with window = rows 2..5.
- Read of rd_address=100 → addr_err pulse, rd_valid=0. Write with Bank_sel[0]=1 at address 127 → addr_err pulse and memory unchanged. rst asserted with win_row_cnt=2 → all outputs 0 next cycle, and data written earlier is still readable.
